// File: rtl/mem_ctrl_pkg.sv
// Shared types, latency limits and parity helper for the mem_ctrl memory controller.
package mem_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    localparam int PAR_MAX_W  = 64;

    // Even-parity bit: XOR of all data bits, so data plus parity has an even count of ones.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_ctrl_rd_pipe.sv
// Read-result pipeline of RD_LAT stages; the last stage holds data between valid reads.
// Carries a parity-error flag when MEM_CTRL_PARITY_EN is defined.
module mem_ctrl_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
`ifdef MEM_CTRL_PARITY_EN
    input  logic              i_perr,
    output logic              o_perr,
`endif
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_data [RD_LAT];
    logic [RD_LAT-1:0] r_vld;

    // Shift valid every cycle; data only advances with valid so it is held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            if (i_vld) begin
                r_data[0] <= i_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_vld  = r_vld[RD_LAT-1];
    assign o_data = r_data[RD_LAT-1];

`ifdef MEM_CTRL_PARITY_EN
    logic [RD_LAT-1:0] r_perr;

    // Error flag is a pulse qualified by valid, so it is never stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= '0;
        end else begin
            r_perr[0] <= i_vld & i_perr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_perr[i] <= r_vld[i-1] & r_perr[i-1];
            end
        end
    end

    assign o_perr = r_perr[RD_LAT-1];
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Parametrised single-clock memory with write-first bypass, zero-fill sweep and read_valid.
// Optional stored even parity and parity_err output under MEM_CTRL_PARITY_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MRead_request,
    input  logic              MWrite_request,
    input  logic [ADDR_W-1:0] read_address,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              clear_req,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
`ifdef MEM_CTRL_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef MEM_CTRL_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_ctrl: RD_LAT must be 1 or 2");
    end
    if (DATA_W > PAR_MAX_W) begin : g_bad_data_w
        $error("mem_ctrl: DATA_W exceeds parity helper width");
    end

    logic [MEM_W-1:0]  r_mem [DEPTH];
    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;

    logic              w_rd_issue;
    logic              w_bypass;
    logic [MEM_W-1:0]  w_wr_word;
    logic [MEM_W-1:0]  w_rd_word;
    logic [DATA_W-1:0] w_rd_data;
`ifdef MEM_CTRL_PARITY_EN
    logic              w_rd_perr;
`endif

    // Read issue, write-first bypass selection and stored-word formatting
    always_comb begin
        w_rd_issue = MRead_request && (r_state == ST_READY);
        w_bypass   = MWrite_request && (write_address == read_address);
        w_rd_word  = r_mem[read_address];
`ifdef MEM_CTRL_PARITY_EN
        w_wr_word  = {even_parity(PAR_MAX_W'(write_data)), write_data};
`else
        w_wr_word  = write_data;
`endif
        if (w_bypass) begin
            w_rd_data = write_data;
        end else begin
            w_rd_data = w_rd_word[DATA_W-1:0];
        end
`ifdef MEM_CTRL_PARITY_EN
        if (w_bypass) begin
            w_rd_perr = 1'b0;
        end else begin
            w_rd_perr = w_rd_word[DATA_W] ^ even_parity(PAR_MAX_W'(w_rd_word[DATA_W-1:0]));
        end
`endif
    end

    // Array write port: zero-fill during the sweep, otherwise the serviced write
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (MWrite_request) begin
            r_mem[write_address] <= w_wr_word;
        end
    end

    // Sweep FSM; the pointer parks at DEPTH-1 rather than wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (clear_req) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign busy = r_busy;

    mem_ctrl_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst),
        .i_vld  (w_rd_issue),
        .i_data (w_rd_data),
`ifdef MEM_CTRL_PARITY_EN
        .i_perr (w_rd_perr),
        .o_perr (parity_err),
`endif
        .o_vld  (read_valid),
        .o_data (read_data)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed, table-driven bench for mem_ctrl; RD_LAT=1 and RD_LAT=2 instances share stimulus.
module tb_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mrd, mwr, clr;
    logic [9:0] ra, wa;
    logic [7:0] wd;
    logic [7:0] rdata, rdata2;
    logic       rvalid, rvalid2, busy, busy2;
`ifdef MEM_CTRL_PARITY_EN
    logic       perr, perr2;
`endif

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    mem_ctrl #(.DATA_W(8), .ADDR_W(10), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .MRead_request(mrd), .MWrite_request(mwr),
        .read_address(ra), .write_address(wa), .write_data(wd), .clear_req(clr),
        .read_data(rdata), .read_valid(rvalid),
`ifdef MEM_CTRL_PARITY_EN
        .parity_err(perr),
`endif
        .busy(busy)
    );

    mem_ctrl #(.DATA_W(8), .ADDR_W(10), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .MRead_request(mrd), .MWrite_request(mwr),
        .read_address(ra), .write_address(wa), .write_data(wd), .clear_req(clr),
        .read_data(rdata2), .read_valid(rvalid2),
`ifdef MEM_CTRL_PARITY_EN
        .parity_err(perr2),
`endif
        .busy(busy2)
    );

    typedef struct {
        logic       rd;
        logic       wr;
        logic [9:0] raddr;
        logic [9:0] waddr;
        logic [7:0] wdata;
        logic       exp_v;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mrd = 1'b0; mwr = 1'b0; clr = 1'b0;
    endtask

    task automatic wait_sweep(input int already);
        cnt = already;
        while (busy === 1'b1 && cnt < 2000) begin
            step();
            cnt++;
        end
        chk("busy_cycles", cnt, 1024);
        chk("busy2_ready", {31'd0, busy2}, 32'd0);
    endtask

    initial begin
        logic       pv;
        logic [7:0] pd;

        vecs[0]  = '{1'b1, 1'b0, 10'h123, 10'h000, 8'h00, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 10'h000, 10'h3FF, 8'hA5, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 10'h3FF, 10'h000, 8'h00, 1'b1, 8'hA5};
        vecs[3]  = '{1'b0, 1'b1, 10'h000, 10'h010, 8'h77, 1'b0, 8'hA5};
        vecs[4]  = '{1'b1, 1'b1, 10'h010, 10'h020, 8'h11, 1'b1, 8'h77};
        vecs[5]  = '{1'b1, 1'b0, 10'h020, 10'h000, 8'h00, 1'b1, 8'h11};
        vecs[6]  = '{1'b1, 1'b1, 10'h010, 10'h010, 8'h5A, 1'b1, 8'h5A};
        vecs[7]  = '{1'b1, 1'b0, 10'h010, 10'h000, 8'h00, 1'b1, 8'h5A};
        vecs[8]  = '{1'b1, 1'b1, 10'h3FF, 10'h000, 8'hC3, 1'b1, 8'hA5};
        vecs[9]  = '{1'b1, 1'b0, 10'h000, 10'h000, 8'h00, 1'b1, 8'hC3};
        vecs[10] = '{1'b0, 1'b0, 10'h000, 10'h000, 8'h00, 1'b0, 8'hC3};
        vecs[11] = '{1'b0, 1'b1, 10'h000, 10'h005, 8'hFF, 1'b0, 8'hC3};
        vecs[12] = '{1'b1, 1'b0, 10'h005, 10'h000, 8'h00, 1'b1, 8'hFF};

        rst = 1'b0; ra = '0; wa = '0; wd = '0;
        idle();
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_valid", {31'd0, rvalid}, 32'd0);
        chk("rst_data", {24'd0, rdata}, 32'd0);
        chk("rst_valid2", {31'd0, rvalid2}, 32'd0);

        // Power-up sweep length
        rst = 1'b1;
        wait_sweep(0);

        // Main table: dut (RD_LAT=1) per vector, dut2 (RD_LAT=2) one vector behind
        pv = 1'b0; pd = 8'h00;
        for (int i = 0; i < 13; i++) begin
            mrd = vecs[i].rd; mwr = vecs[i].wr;
            ra = vecs[i].raddr; wa = vecs[i].waddr; wd = vecs[i].wdata;
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, rvalid}, {31'd0, vecs[i].exp_v});
            chk($sformatf("v%0d_data", i), {24'd0, rdata}, {24'd0, vecs[i].exp_d});
            chk($sformatf("v%0d_valid2", i), {31'd0, rvalid2}, {31'd0, pv});
            chk($sformatf("v%0d_data2", i), {24'd0, rdata2}, {24'd0, pd});
            pv = vecs[i].exp_v; pd = vecs[i].exp_d;
        end
        idle();
        step();
        chk("tail_valid2", {31'd0, rvalid2}, 32'd1);
        chk("tail_data2", {24'd0, rdata2}, 32'hFF);

        // clear_req with a same-cycle read, then dropped requests during the sweep
        clr = 1'b1; mrd = 1'b1; ra = 10'h005;
        step();
        clr = 1'b0;
        chk("clr_cycle_valid", {31'd0, rvalid}, 32'd1);
        chk("clr_cycle_data", {24'd0, rdata}, 32'hFF);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        chk("clr_valid2_early", {31'd0, rvalid2}, 32'd0);
        step();
        chk("busy_read_dropped", {31'd0, rvalid}, 32'd0);
        chk("inflight_valid2", {31'd0, rvalid2}, 32'd1);
        chk("inflight_data2", {24'd0, rdata2}, 32'hFF);
        mrd = 1'b0; mwr = 1'b1; wa = 10'h000; wd = 8'h99;
        step();
        mwr = 1'b0;
        chk("busy_valid2_none", {31'd0, rvalid2}, 32'd0);
        wait_sweep(2);
        mrd = 1'b1; ra = 10'h005;
        step();
        chk("swept_valid", {31'd0, rvalid}, 32'd1);
        chk("swept_data", {24'd0, rdata}, 32'h00);
        ra = 10'h000;
        step();
        chk("busy_write_dropped", {24'd0, rdata}, 32'h00);

        // Reset in the middle of a sweep
        mrd = 1'b0; mwr = 1'b1; wa = 10'h3FF; wd = 8'h66;
        step();
        mwr = 1'b0; mrd = 1'b1; ra = 10'h3FF;
        step();
        mrd = 1'b0;
        chk("pre_sweep_data", {24'd0, rdata}, 32'h66);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (499) step();
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk("midrst_data", {24'd0, rdata}, 32'h00);
        chk("midrst_valid", {31'd0, rvalid}, 32'd0);
        step();
        step();
        rst = 1'b1;
        wait_sweep(0);
        mrd = 1'b1; ra = 10'h3FF;
        step();
        mrd = 1'b0;
        chk("post_rst_data", {24'd0, rdata}, 32'h00);
        chk("post_rst_valid", {31'd0, rvalid}, 32'd1);

`ifdef MEM_CTRL_PARITY_EN
        // Corrupted stored bit, clean read, and bypass read
        mwr = 1'b1; wa = 10'h001; wd = 8'h5A;
        step();
        mwr = 1'b0;
        dut.r_mem[1][0] = ~dut.r_mem[1][0];
        mrd = 1'b1; ra = 10'h001;
        step();
        chk("par_bad_valid", {31'd0, rvalid}, 32'd1);
        chk("par_bad_err", {31'd0, perr}, 32'd1);
        chk("par_bad_data", {24'd0, rdata}, 32'h5B);
        ra = 10'h002;
        step();
        chk("par_ok_err", {31'd0, perr}, 32'd0);
        mwr = 1'b1; wa = 10'h001; wd = 8'h07; ra = 10'h001;
        step();
        idle();
        chk("par_bypass_err", {31'd0, perr}, 32'd0);
        chk("par_bypass_data", {24'd0, rdata}, 32'h07);
        step();
        chk("par_idle_err", {31'd0, perr}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
